dsp_op_sequencer: RTL

- Front-end controller for the fused multiply-accumulate DSP slice. Accepts one operation per valid/ready handshake and registers its operands.
- Drives the slice's start/mode/operand/mac/barrel_shifter inputs for the correct number of consecutive issue cycles: 1 for mode 0, 2 for mode 1, 4 for mode 2.
- Captures the slice output at the correct cycle and returns it as a one-cycle result pulse.
- Ops may issue back-to-back with no bubble.

---
 rtl/dsp_op_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dsp_op_sequencer.sv
// Front-end sequencer for the fused MAC DSP slice: accepts one op per handshake,
// issues it for 1/2/4 contiguous cycles and returns the slice result as a one-cycle pulse.
module dsp_op_sequencer #(
  parameter int N       = 16,
  parameter int M       = 16,
  parameter int RES_LAT = 0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [1:0]       i_req_mode,
  input  logic [N-1:0]     i_req_a,
  input  logic [M-1:0]     i_req_b,
  input  logic [N+M-1:0]   i_req_c,
  input  logic             i_req_mac,
  input  logic [1:0]       i_req_shift,
  output logic             o_dsp_start,
  output logic [1:0]       o_dsp_mode,
  output logic [N-1:0]     o_dsp_aa,
  output logic [M-1:0]     o_dsp_bb,
  output logic [N+M-1:0]   o_dsp_cc,
  output logic             o_dsp_mac,
  output logic [1:0]       o_dsp_barrel_shifter,
  input  logic [N+M-1:0]   i_dsp_out,
  output logic             o_res_valid,
  output logic [N+M-1:0]   o_res_data,
  output logic             o_res_err,
  output logic             o_busy
);

  localparam int DMAX = 4 + RES_LAT;

  typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

  state_t          r_state, w_nextState;
  logic [1:0]      r_cnt, w_nextCnt, r_lastCnt;
  logic            r_err;
  logic [1:0]      r_mode, r_shift;
  logic [N-1:0]    r_aa;
  logic [M-1:0]    r_bb;
  logic [N+M-1:0]  r_cc;
  logic            r_mac;
  logic [DMAX-1:0] r_tag, r_tagErr;

  logic            w_accept, w_reqIllegal, w_lastSlot;
  logic [1:0]      w_reqLastCnt;
  logic [2:0]      w_insIdx;
  logic [DMAX-1:0] w_tagIns;

  // A tag enters the shift register at depth L+RES_LAT-1 so it reaches slot 0 on the sampling cycle.
  always_comb begin
    w_reqIllegal = (i_req_mode == 2'd3);
    case (i_req_mode)
      2'd1:    w_reqLastCnt = 2'd1;
      2'd2:    w_reqLastCnt = 2'd3;
      default: w_reqLastCnt = 2'd0;
    endcase
    w_insIdx = {1'b0, w_reqLastCnt} + 3'(RES_LAT);
    w_tagIns = w_accept ? (DMAX'(1) << w_insIdx) : '0;
  end

  assign w_lastSlot = (r_state == ST_ISSUE) && (r_cnt == r_lastCnt);
  assign w_accept   = i_req_valid & o_req_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_nextState = ST_ISSUE;
          w_nextCnt   = 2'd0;
        end
      end
      ST_ISSUE: begin
        if (r_cnt == r_lastCnt) begin
          w_nextState = w_accept ? ST_ISSUE : ST_IDLE;
          w_nextCnt   = 2'd0;
        end else begin
          w_nextCnt = r_cnt + 2'd1;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
        w_nextCnt   = 2'd0;
      end
    endcase
  end

  // An illegal op occupies its slot like a one-cycle op but never pulses start.
  always_comb begin
    o_req_ready = ~i_reset & ((r_state == ST_IDLE) | w_lastSlot);
    o_dsp_start = (r_state == ST_ISSUE) && (r_cnt == 2'd0) && !r_err;
    o_busy      = (r_state != ST_IDLE) || (|r_tag);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_err     <= 1'b0;
      r_lastCnt <= 2'd0;
      r_mode    <= 2'd0;
      r_shift   <= 2'd0;
      r_aa      <= '0;
      r_bb      <= '0;
      r_cc      <= '0;
      r_mac     <= 1'b0;
    end else if (w_accept) begin
      r_err     <= w_reqIllegal;
      r_lastCnt <= w_reqLastCnt;
      if (!w_reqIllegal) begin
        r_mode  <= i_req_mode;
        r_shift <= i_req_shift;
        r_aa    <= i_req_a;
        r_bb    <= i_req_b;
        r_cc    <= i_req_c;
        r_mac   <= i_req_mac;
      end
    end
  end

  assign o_dsp_mode           = r_mode;
  assign o_dsp_aa             = r_aa;
  assign o_dsp_bb             = r_bb;
  assign o_dsp_cc             = r_cc;
  assign o_dsp_mac            = r_mac;
  assign o_dsp_barrel_shifter = r_shift;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tag       <= '0;
      r_tagErr    <= '0;
      o_res_valid <= 1'b0;
      o_res_err   <= 1'b0;
      o_res_data  <= '0;
    end else begin
      r_tag       <= {1'b0, r_tag[DMAX-1:1]} | w_tagIns;
      r_tagErr    <= {1'b0, r_tagErr[DMAX-1:1]} | (w_reqIllegal ? w_tagIns : '0);
      o_res_valid <= r_tag[0];
      o_res_err   <= r_tag[0] & r_tagErr[0];
      if (r_tag[0]) begin
        o_res_data <= r_tagErr[0] ? '0 : i_dsp_out;
      end
    end
  end

endmodule
